// File: rtl/deser_frame_ctrl_if.sv
// Downstream payload stream for deser_frame_ctrl: head word, last flag and
// valid/ready handshake. The controller drives through the master modport.
interface deser_frame_ctrl_if;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  modport master (
    output m_data,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_last,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/deser_frame_ctrl.sv
// Frame controller for the serial-to-parallel path.
// Hunts the deserializer window for SYNC_WORD, then captures FRAME_LEN payload
// words on exact 32-bit boundaries, re-checking sync after each frame with
// flywheel tolerance of LOCK_MISS-1 missed sync words. Captured words go out
// through a 2-entry valid/ready buffer with a sticky overflow flag.
// Optional feature: define DESER_FRAME_CNT_EN to build the 16-bit frame_cnt
// register; otherwise frame_cnt is tied to zero.
module deser_frame_ctrl #(
  parameter logic [31:0] SYNC_WORD = 32'hA5A5_0F0F,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned LOCK_MISS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [31:0]         des_word,
  deser_frame_ctrl_if.master  m_if,
  output logic                locked,
  output logic                overflow,
  input  logic                clr_ovf,
  output logic [15:0]         frame_cnt
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [3:0] MISS_LIM = 4'(LOCK_MISS);

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;

  logic        sync_hit;
  logic        boundary;
  logic        push;
  logic        push_last;

  // Buffer storage: head is what the consumer sees, tail is the second entry.
  logic [31:0] head_data_q, head_data_d;
  logic        head_last_q, head_last_d;
  logic [31:0] tail_data_q, tail_data_d;
  logic        tail_last_q, tail_last_d;
  logic [1:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        valid;
  logic        pop;
  logic        drop;

  assign sync_hit  = (des_word == SYNC_WORD);
  assign boundary  = (bit_cnt_q == 5'd31);
  assign push_last = (word_cnt_q == LAST_IDX);

  // Framing state and counters register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Framing next-state: sync hunt, boundary capture and sync re-check.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    miss_cnt_d = miss_cnt_q;
    push       = 1'b0;
    if (!en) begin
      state_d    = HUNT;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      miss_cnt_d = '0;
    end else begin
      case (state_q)
        HUNT: begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          if (sync_hit) begin
            state_d    = PAYLOAD;
            miss_cnt_d = '0;
          end
        end
        PAYLOAD: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (boundary) begin
            push       = 1'b1;
            word_cnt_d = word_cnt_q + 8'd1;
            if (push_last) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (boundary) begin
            word_cnt_d = '0;
            if (sync_hit) begin
              miss_cnt_d = '0;
              state_d    = PAYLOAD;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
              if ((miss_cnt_q + 4'd1) == MISS_LIM) begin
                state_d = HUNT;
              end else begin
                state_d = PAYLOAD;
              end
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  assign locked = (state_q != HUNT);

  assign valid = (count_q != 2'd0);
  assign pop   = valid & m_if.m_ready;
  assign drop  = push & (count_q == 2'd2) & ~pop;

  // Buffer and overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Buffer update: a pop frees a slot in the same cycle, so a full buffer
  // accepts a concurrent push by shifting tail to head.
  always_comb begin
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    count_d     = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_data_d = des_word;
          head_last_d = push_last;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = des_word;
          head_last_d = push_last;
        end else if (pop) begin
          count_d = 2'd0;
        end else if (push) begin
          tail_data_d = des_word;
          tail_last_d = push_last;
          count_d     = 2'd2;
        end
      end
      2'd2: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          if (push) begin
            tail_data_d = des_word;
            tail_last_d = push_last;
          end else begin
            count_d = 2'd1;
          end
        end
      end
      default: begin
        count_d = '0;
      end
    endcase

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  assign m_if.m_data  = head_data_q;
  assign m_if.m_last  = head_last_q;
  assign m_if.m_valid = valid;
  assign overflow     = overflow_q;

`ifdef DESER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        frame_inc;

  // A confirmed sync is a hunt match or a matching sync slot; flywheel
  // slots do not count.
  assign frame_inc = en & sync_hit &
                     ((state_q == HUNT) || ((state_q == CHECK) && boundary));

  // Confirmed-sync counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_inc) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Self-checking bench for deser_frame_ctrl: directed frame scenarios followed
// by randomized frames, checked by a scoreboard against a stream-level model.
module tb_deser_frame_ctrl;

  localparam logic [31:0] SYNC  = 32'hA5A5_0F0F;
  localparam int          FLEN  = 4;
  localparam int          LMISS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr_ovf;
  logic [31:0] des_word;
  logic        locked;
  logic        overflow;
  logic [15:0] frame_cnt;

  deser_frame_ctrl_if dif ();

  deser_frame_ctrl #(
    .SYNC_WORD (SYNC),
    .FRAME_LEN (FLEN),
    .LOCK_MISS (LMISS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .des_word  (des_word),
    .m_if      (dif),
    .locked    (locked),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  int total = 0;
  int bad   = 0;

  // Reference model: lock flag, absolute cycle of the next 32-bit boundary,
  // words captured in the current frame, consecutive misses, frame count,
  // buffer contents and sticky overflow.
  beat_t       mq[$];
  beat_t       sb_q[$];
  bit          m_lock;
  int          m_next;
  int          m_words;
  int          m_miss;
  logic [15:0] m_fcnt;
  bit          m_ovf;
  int          cyc;

  function automatic void chk(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    sb_q.delete();
    m_lock  = 1'b0;
    m_next  = 0;
    m_words = 0;
    m_miss  = 0;
    m_fcnt  = '0;
    m_ovf   = 1'b0;
  endfunction

  // One clock edge worth of the stream rules, using the inputs that edge sampled.
  function automatic void model_step();
    beat_t b;
    bit    pop;
    bit    push;
    bit    drop;
    b    = '0;
    push = 1'b0;
    drop = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop = (mq.size() != 0) && dif.m_ready;
    if (!en) begin
      m_lock = 1'b0;
      m_miss = 0;
    end else if (!m_lock) begin
      if (des_word == SYNC) begin
        m_lock  = 1'b1;
        m_next  = cyc + 32;
        m_words = 0;
        m_miss  = 0;
        m_fcnt  = m_fcnt + 16'd1;
      end
    end else if (cyc == m_next) begin
      m_next = cyc + 32;
      if (m_words < FLEN) begin
        push = 1'b1;
        b.d  = des_word;
        b.l  = (m_words == FLEN - 1);
        m_words++;
      end else if (des_word == SYNC) begin
        m_miss  = 0;
        m_fcnt  = m_fcnt + 16'd1;
        m_words = 0;
      end else begin
        m_miss++;
        if (m_miss == LMISS) m_lock = 1'b0;
        else m_words = 0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < 2) begin
        mq.push_back(b);
        sb_q.push_back(b);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    cyc++;
  endtask

  // rmode: 0 ready high, 1 ready low, 2 ready random (mostly high)
  task automatic send_bit(input logic b, input int rmode);
    des_word = {des_word[30:0], b};
    case (rmode)
      0:       dif.m_ready = 1'b1;
      1:       dif.m_ready = 1'b0;
      default: dif.m_ready = ($urandom_range(0, 3) != 0);
    endcase
    tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int rmode, input bit clr);
    for (int i = 31; i >= 0; i--) begin
      clr_ovf = clr && (i == 31);
      send_bit(w[i], rmode);
    end
    clr_ovf = 1'b0;
  endtask

  task automatic send_frame_words(input logic [31:0] w0, input logic [31:0] w1,
                                  input logic [31:0] w2, input logic [31:0] w3,
                                  input int rmode);
    send_word(w0, rmode, 1'b0);
    send_word(w1, rmode, 1'b0);
    send_word(w2, rmode, 1'b0);
    send_word(w3, rmode, 1'b0);
  endtask

  task automatic send_rand_words(input int n, input int rmode);
    for (int i = 0; i < n; i++) send_word($urandom, rmode, 1'b0);
  endtask

  // Monitor: outputs here equal those seen at the next rising edge, so a
  // visible valid&ready is the beat that edge transfers.
  always @(negedge clk) begin
    logic [15:0] exp_fc;
    beat_t       e;
`ifdef DESER_FRAME_CNT_EN
    exp_fc = m_fcnt;
`else
    exp_fc = 16'h0000;
`endif
    chk("m_valid", {31'd0, dif.m_valid}, {31'd0, mq.size() != 0});
    chk("locked", {31'd0, locked}, {31'd0, m_lock});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
    if (dif.m_valid === 1'b1 && dif.m_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", dif.m_data, 32'h0);
        chk("unexpected_beat_present", 32'd1, {31'd0, (sb_q.size() != 0)});
      end else begin
        e = sb_q.pop_front();
        chk("m_data", dif.m_data, e.d);
        chk("m_last", {31'd0, dif.m_last}, {31'd0, e.l});
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    clr_ovf     = 1'b0;
    des_word    = '0;
    dif.m_ready = 1'b0;
    cyc         = 0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b0, 0);

    // Acquire
    send_word(SYNC, 0, 1'b0);
    send_frame_words(32'h0102_0304, 32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF, 0);
    // Confirmed sync, then a flywheeled slot, then re-confirm
    send_word(SYNC, 0, 1'b0);
    send_rand_words(4, 0);
    send_word(32'h0000_0000, 0, 1'b0);
    send_rand_words(4, 0);
    send_word(SYNC, 0, 1'b0);

    // Backpressure through a whole frame: words 2 and 3 dropped
    send_frame_words(32'h0102_0304, 32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF, 1);
    send_word(SYNC, 0, 1'b1);
    send_rand_words(4, 0);

    // Loss of lock after two consecutive bad sync slots
    send_word(32'h0000_0000, 0, 1'b0);
    send_rand_words(4, 0);
    send_word(32'h0000_0000, 0, 1'b0);
    send_rand_words(3, 0);

    // Misaligned stream
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), 0);
    send_word(SYNC, 0, 1'b0);
    send_frame_words(32'h0102_0304, 32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF, 0);

    // en drop 40 bits into the payload, buffer holds word 0
    send_word(SYNC, 0, 1'b0);
    send_word(32'hCAFE_0001, 1, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)), 1);
    en = 1'b0;
    for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)), 1);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 0);
    en = 1'b1;

    // rst_n low 40 bits into the payload
    send_word(SYNC, 0, 1'b0);
    send_word(32'hCAFE_0002, 1, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_m_valid", {31'd0, dif.m_valid}, 32'd0);
    chk("rst_m_data", dif.m_data, 32'd0);
    chk("rst_m_last", {31'd0, dif.m_last}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b0, 0);

    // Randomized frames: occasional bad sync slots, random ready and clears
    send_word(SYNC, 2, 1'b0);
    for (int f = 0; f < 24; f++) begin
      send_rand_words(FLEN, 2);
      if ($urandom_range(0, 4) == 0) send_word($urandom, 2, ($urandom_range(0, 3) == 0));
      else send_word(SYNC, 2, ($urandom_range(0, 3) == 0));
    end

    // Drain
    en = 1'b0;
    for (int i = 0; i < 20; i++) send_bit(1'b0, 0);
    chk("drain_left", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
